// File: rtl/ramp_monitor.sv
// Ascending-ramp checker: watches a sample stream for 0,1,...,LAST and reports
// sample count, sequence breaks, the first bad sample and a pass/fail flag.
module ramp_monitor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAST  = 254,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             sweep_ok,
    output logic [WIDTH:0]   sample_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_bad_data,
    output logic [WIDTH-1:0] first_bad_exp
);

    localparam logic [WIDTH-1:0] LastVal = WIDTH'(LAST);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] expected;

    logic             is_break;
    logic             is_last;
    logic [WIDTH:0]   cnt_next;
    logic [ERR_W-1:0] err_next;
    logic [WIDTH-1:0] exp_next;

    always_comb begin
        is_break = (in_data != expected);
        is_last  = (in_data == LastVal);
        cnt_next = (sample_cnt == '1) ? sample_cnt : sample_cnt + (WIDTH+1)'(1);
        err_next = err_cnt;
        if (is_break && (err_cnt != '1)) begin
            err_next = err_cnt + ERR_W'(1);
        end
        // On a match in_data+1 equals expected+1, so one path covers match and resync.
        exp_next = in_data + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state          <= StIdle;
            expected       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sweep_ok       <= 1'b0;
            sample_cnt     <= '0;
            err_cnt        <= '0;
            first_bad_data <= '0;
            first_bad_exp  <= '0;
        end else begin
            done <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    StIdle, StDone: begin
                        if (in_data == '0) begin
                            state          <= StRun;
                            expected       <= WIDTH'(1);
                            busy           <= 1'b1;
                            sample_cnt     <= (WIDTH+1)'(1);
                            err_cnt        <= '0;
                            first_bad_data <= '0;
                            first_bad_exp  <= '0;
                        end
                    end
                    StRun: begin
                        sample_cnt <= cnt_next;
                        expected   <= exp_next;
                        err_cnt    <= err_next;
                        if (is_break && (err_cnt == '0)) begin
                            first_bad_data <= in_data;
                            first_bad_exp  <= expected;
                        end
                        if (is_last) begin
                            state    <= StDone;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            sweep_ok <= (err_next == '0);
                        end
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ramp_monitor.sv
// Bench for ramp_monitor: directed sweeps, a vector table and random streams
// checked against an integer reference model; a second instance uses ERR_W = 4.
module tb_ramp_monitor;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, clear;
    logic [7:0] in_data;

    logic       busy, done, sweep_ok;
    logic [8:0] sample_cnt;
    logic [7:0] err_cnt, first_bad_data, first_bad_exp;

    logic       busy4, done4, sweep_ok4;
    logic [8:0] sample_cnt4;
    logic [3:0] err_cnt4;
    logic [7:0] first_bad_data4, first_bad_exp4;

    int checks   = 0;
    int failures = 0;

    // Reference model state: phase 0 = waiting for a 0, 1 = in a sweep, 2 = finished
    int m_phase, m_exp, m_cnt, m_err, m_fbd, m_fbe, m_ok, m_done;

    always #5 clk = ~clk;

    ramp_monitor #(.WIDTH(8), .LAST(254), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .busy(busy), .done(done), .sweep_ok(sweep_ok), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .first_bad_data(first_bad_data), .first_bad_exp(first_bad_exp)
    );

    ramp_monitor #(.WIDTH(8), .LAST(254), .ERR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .busy(busy4), .done(done4), .sweep_ok(sweep_ok4), .sample_cnt(sample_cnt4),
        .err_cnt(err_cnt4), .first_bad_data(first_bad_data4), .first_bad_exp(first_bad_exp4)
    );

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit clr, input bit v, input int d);
        m_done = 0;
        if (!rst || clr) begin
            m_phase = 0; m_exp = 0; m_cnt = 0; m_err = 0;
            m_fbd = 0; m_fbe = 0; m_ok = 0;
            return;
        end
        if (!v) return;
        if (m_phase != 1) begin
            if (d == 0) begin
                m_phase = 1; m_exp = 1; m_cnt = 1; m_err = 0; m_fbd = 0; m_fbe = 0;
            end
        end else begin
            m_cnt = min_i(m_cnt + 1, 511);
            if (d != m_exp) begin
                if (m_err == 0) begin
                    m_fbd = d;
                    m_fbe = m_exp;
                end
                m_err++;
                m_exp = (d + 1) % 256;
            end else begin
                m_exp = (m_exp + 1) % 256;
            end
            if (d == 254) begin
                m_phase = 2;
                m_done  = 1;
                m_ok    = (m_err == 0);
            end
        end
    endtask

    task automatic compare_model();
        check("busy", int'(busy), int'(m_phase == 1));
        check("done", int'(done), m_done);
        check("sweep_ok", int'(sweep_ok), m_ok);
        check("sample_cnt", int'(sample_cnt), m_cnt);
        check("err_cnt", int'(err_cnt), min_i(m_err, 255));
        check("first_bad_data", int'(first_bad_data), m_fbd);
        check("first_bad_exp", int'(first_bad_exp), m_fbe);
        check("err_cnt4", int'(err_cnt4), min_i(m_err, 15));
        check("sweep_ok4", int'(sweep_ok4), m_ok);
        check("done4", int'(done4), m_done);
    endtask

    task automatic cycle(input bit rst, input bit clr, input bit v, input int d);
        rst_n    = rst;
        clear    = clr;
        in_valid = v;
        in_data  = 8'(d);
        @(posedge clk);
        model_step(rst, clr, v, d);
        #1;
        compare_model();
    endtask

    // Ramp 0..254 in steps of stp, omitting value skip; optional idle cycle before each sample
    task automatic sweep(input int skip, input int stp, input bit gaps);
        for (int x = 0; x <= 254; x += stp) begin
            if (x == skip) continue;
            if (gaps) cycle(1, 0, 0, 0);
            cycle(1, 0, 1, x);
        end
    endtask

    typedef struct {
        bit rst;
        bit clr;
        bit v;
        int d;
        int e_busy;
        int e_done;
        int e_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int last_sent;

        vecs.push_back('{1, 0, 1, 5,   0, 0, 0});
        vecs.push_back('{1, 0, 1, 7,   0, 0, 0});
        vecs.push_back('{1, 0, 1, 0,   1, 0, 1});
        vecs.push_back('{1, 0, 1, 1,   1, 0, 2});
        vecs.push_back('{1, 0, 1, 2,   1, 0, 3});
        vecs.push_back('{1, 1, 0, 0,   0, 0, 0});
        vecs.push_back('{1, 0, 1, 3,   0, 0, 0});
        vecs.push_back('{1, 0, 1, 0,   1, 0, 1});
        vecs.push_back('{1, 1, 1, 254, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 254, 0, 0, 0});

        m_phase = 0; m_exp = 0; m_cnt = 0; m_err = 0;
        m_fbd = 0; m_fbe = 0; m_ok = 0; m_done = 0;

        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cnt", int'(sample_cnt), 0);

        // Clean sweep
        sweep(-1, 1, 0);
        check("clean_done", int'(done), 1);
        check("clean_busy", int'(busy), 0);
        check("clean_cnt", int'(sample_cnt), 255);
        check("clean_err", int'(err_cnt), 0);
        check("clean_ok", int'(sweep_ok), 1);
        cycle(1, 0, 0, 0);
        check("clean_done_width", int'(done), 0);

        // Valid toggling every cycle
        sweep(-1, 1, 1);
        check("gap_done", int'(done), 1);
        check("gap_cnt", int'(sample_cnt), 255);
        check("gap_ok", int'(sweep_ok), 1);
        cycle(1, 0, 0, 0);
        check("gap_done_width", int'(done), 0);

        // Missing 100
        sweep(100, 1, 0);
        check("skip_err", int'(err_cnt), 1);
        check("skip_fbd", int'(first_bad_data), 101);
        check("skip_fbe", int'(first_bad_exp), 100);
        check("skip_cnt", int'(sample_cnt), 254);
        check("skip_ok", int'(sweep_ok), 0);

        // Even values only: 127 breaks
        sweep(-1, 2, 0);
        check("even_err4", int'(err_cnt4), 15);
        check("even_err8", int'(err_cnt), 127);
        check("even_fbd", int'(first_bad_data4), 2);
        check("even_fbe", int'(first_bad_exp4), 1);
        check("even_ok", int'(sweep_ok4), 0);

        // Vector table: IDLE filtering, clear, clear beating LAST
        cycle(0, 0, 0, 0);
        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].clr, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d_busy", i), int'(busy), vecs[i].e_busy);
            check($sformatf("vec%0d_done", i), int'(done), vecs[i].e_done);
            check($sformatf("vec%0d_cnt", i), int'(sample_cnt), vecs[i].e_cnt);
        end

        // Back-to-back sweeps with reset during the second
        sweep(-1, 1, 0);
        check("b2b_ok1", int'(sweep_ok), 1);
        for (int x = 0; x < 50; x++) cycle(1, 0, 1, x);
        cycle(0, 0, 1, 50);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ok", int'(sweep_ok), 0);
        check("rst_cnt", int'(sample_cnt), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_fbd", int'(first_bad_data), 0);
        check("rst_fbe", int'(first_bad_exp), 0);
        sweep(-1, 1, 0);
        check("after_rst_ok", int'(sweep_ok), 1);
        check("after_rst_done", int'(done), 1);

        // Random mostly-ramp streams
        last_sent = 0;
        for (int n = 0; n < 6000; n++) begin
            bit clr, v;
            int d, r;
            clr = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 99);
            if (r < 85)      d = (last_sent + 1) % 256;
            else if (r < 90) d = 0;
            else if (r < 93) d = 254;
            else             d = $urandom_range(0, 255);
            if (v) last_sent = d;
            cycle(1, clr, v, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
